// File: rtl/c7bifu_fetch.sv
// c7bifu_fetch: sequential fetch PC generation, in-order i-cache response tracking
// and a 2-entry instruction queue feeding decode. A flush redirects the PC and
// discards the responses still in flight for requests issued before it.
module c7bifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        icu_req,
  output logic [31:0] icu_addr,
  input  logic        icu_ack,
  input  logic        icu_rvld,
  input  logic [31:0] icu_rdata,
  output logic        inst_vld_f,
  output logic [31:0] inst_addr_f,
  output logic [31:0] inst_f
);

  logic [31:0] pc_q;
  logic [31:0] raddr_q [2];
  logic        rf_wp;
  logic        rf_rp;
  logic [1:0]  out_cnt;
  logic [1:0]  kill_cnt;
  logic [31:0] q_pc   [2];
  logic [31:0] q_inst [2];
  logic        q_wp;
  logic        q_rp;
  logic [1:0]  q_cnt;

  logic        pop;
  logic        accept;
  logic        push;
  logic [2:0]  credit;

  // Credit check counts the slot freed by this cycle's pop so k=1 streams at full rate.
  always_comb begin
    pop     = (q_cnt != 2'd0) & ~stall & ~flush;
    credit  = {1'b0, q_cnt} + {1'b0, out_cnt} - {2'b00, pop};
    icu_req = ~reset & ~flush & (credit < 3'd2);
    accept  = icu_req & icu_ack;
    push    = icu_rvld & ~flush & (kill_cnt == 2'd0);
  end

  assign icu_addr    = pc_q;
  assign inst_vld_f  = (q_cnt != 2'd0);
  assign inst_addr_f = q_pc[q_rp];
  assign inst_f      = q_inst[q_rp];

  // Fetch PC, outstanding-request address FIFO, and outstanding/kill counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      raddr_q[0] <= '0;
      raddr_q[1] <= '0;
      rf_wp      <= 1'b0;
      rf_rp      <= 1'b0;
      out_cnt    <= 2'd0;
      kill_cnt   <= 2'd0;
    end else begin
      if (flush) begin
        pc_q <= flush_pc;
      end else if (accept) begin
        pc_q <= pc_q + 32'd4;
      end
      if (accept) begin
        raddr_q[rf_wp] <= pc_q;
        rf_wp          <= ~rf_wp;
      end
      if (icu_rvld) begin
        rf_rp <= ~rf_rp;
      end
      case ({accept, icu_rvld})
        2'b10:   out_cnt <= out_cnt + 2'd1;
        2'b01:   out_cnt <= out_cnt - 2'd1;
        default: out_cnt <= out_cnt;
      endcase
      // Everything still outstanding at a flush is stale; a response landing
      // in the flush cycle is dropped directly and so is not counted.
      if (flush) begin
        kill_cnt <= out_cnt - {1'b0, icu_rvld};
      end else if (icu_rvld && (kill_cnt != 2'd0)) begin
        kill_cnt <= kill_cnt - 2'd1;
      end
    end
  end

  // Instruction queue: written by live responses, drained by decode, cleared on flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_pc[0]   <= '0;
      q_pc[1]   <= '0;
      q_inst[0] <= '0;
      q_inst[1] <= '0;
      q_wp      <= 1'b0;
      q_rp      <= 1'b0;
      q_cnt     <= 2'd0;
    end else if (flush) begin
      q_wp  <= 1'b0;
      q_rp  <= 1'b0;
      q_cnt <= 2'd0;
    end else begin
      if (push) begin
        q_pc[q_wp]   <= raddr_q[rf_rp];
        q_inst[q_wp] <= icu_rdata;
        q_wp         <= ~q_wp;
      end
      if (pop) begin
        q_rp <= ~q_rp;
      end
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + 2'd1;
        2'b01:   q_cnt <= q_cnt - 2'd1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // A response with nothing outstanding means the cache and fetch disagree.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(icu_rvld && (out_cnt == 2'd0)));
    end
  end

endmodule

// File: tb/tb_c7bifu_fetch.sv
// Bench for c7bifu_fetch: a behavioural i-cache with programmable latency and an
// ack budget drives the DUT; expected {addr,data} pairs go into a scoreboard queue
// and a monitor pops/compares every instruction decode consumes.
module tb_c7bifu_fetch;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        icu_ack = 1'b0;
  logic        icu_rvld = 1'b0;
  logic [31:0] icu_rdata = '0;
  logic        icu_req;
  logic [31:0] icu_addr;
  logic        inst_vld_f;
  logic [31:0] inst_addr_f;
  logic [31:0] inst_f;

  logic        reset_w = 1'b1;
  logic        req_w;
  logic [31:0] addr_w;
  logic        vld_w;
  logic [31:0] iaddr_w;
  logic [31:0] inst_w;

  exp_t  exp_q [$];
  pend_t pend  [$];
  int    cyc = 0;
  int    lat = 1;
  int    budget = 0;
  bit    ack_en = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;

  c7bifu_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .icu_req     (icu_req),
    .icu_addr    (icu_addr),
    .icu_ack     (icu_ack),
    .icu_rvld    (icu_rvld),
    .icu_rdata   (icu_rdata),
    .inst_vld_f  (inst_vld_f),
    .inst_addr_f (inst_addr_f),
    .inst_f      (inst_f)
  );

  c7bifu_fetch #(.RESET_PC(32'hffff_fffc)) dut_w (
    .clk         (clk),
    .reset       (reset_w),
    .stall       (1'b0),
    .flush       (1'b0),
    .flush_pc    (32'h0),
    .icu_req     (req_w),
    .icu_addr    (addr_w),
    .icu_ack     (1'b1),
    .icu_rvld    (1'b0),
    .icu_rdata   (32'h0),
    .inst_vld_f  (vld_w),
    .inst_addr_f (iaddr_w),
    .inst_f      (inst_w)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] rdat(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_3c3c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{addr: base + 32'(4 * i), data: rdat(base + 32'(4 * i))});
    end
  endtask

  // One clock: cache samples accepts before the edge, presents responses after it.
  task automatic step();
    @(negedge clk);
    icu_ack = ack_en && (budget > 0);
    if (!reset && icu_req && icu_ack) begin
      pend.push_back('{due: cyc + lat, addr: icu_addr});
      budget--;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (reset) pend.delete();
    icu_rvld  = 1'b0;
    icu_rdata = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      icu_rvld  = 1'b1;
      icu_rdata = rdat(pend[0].addr);
      void'(pend.pop_front());
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    stall  = 1'b0;
    flush  = 1'b0;
    ack_en = 1'b0;
    budget = 0;
    repeat (3) step();
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_vld(input string name);
    for (int i = 0; i < 20 && !inst_vld_f; i++) step();
    check(name, 32'(inst_vld_f), 32'd1);
  endtask

  task automatic drain(input string name, input int max);
    for (int i = 0; i < max && exp_q.size() > 0; i++) step();
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (2) step();
    check({name, "_no_extra"}, 32'(inst_vld_f), 32'd0);
  endtask

  // Monitor: every instruction decode takes must be the next expected one.
  always @(negedge clk) begin
    if (!reset && inst_vld_f && !stall && !flush) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got addr %h data %h expected none", inst_addr_f, inst_f);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_addr", inst_addr_f, e.addr);
        check("out_data", inst_f, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state and first request
    repeat (3) step();
    check("rst_req", 32'(icu_req), 32'd0);
    check("rst_vld", 32'(inst_vld_f), 32'd0);
    check("rst_addr_f", inst_addr_f, 32'h0);
    check("rst_inst_f", inst_f, 32'h0);
    reset = 1'b0;
    #1;
    check("first_req", 32'(icu_req), 32'd1);
    check("first_addr", icu_addr, 32'h1c00_0000);

    // Streaming, latency 1: six back-to-back instructions
    lat = 1;
    budget = 6;
    ack_en = 1'b1;
    push_exp(32'h1c00_0000, 6);
    step();
    check("stream_no_bypass", 32'(inst_vld_f), 32'd0);
    wait_vld("stream_first_vld");
    for (int i = 0; i < 6; i++) begin
      check("stream_no_bubble", 32'(inst_vld_f), 32'd1);
      step();
    end
    check("stream_end_vld", 32'(inst_vld_f), 32'd0);
    check("stream_sb_empty", 32'(exp_q.size()), 32'd0);

    // Stall four cycles with the second instruction at the head
    do_reset();
    lat = 1;
    budget = 6;
    ack_en = 1'b1;
    push_exp(32'h1c00_0000, 6);
    wait_vld("stall_first_vld");
    step();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_head", inst_addr_f, 32'h1c00_0004);
      check("stall_req_off", 32'(icu_req), 32'd0);
      step();
    end
    stall = 1'b0;
    drain("stall_drain", 40);

    // Flush with two requests in flight, latency 3
    do_reset();
    lat = 3;
    budget = 2;
    ack_en = 1'b1;
    step();
    step();
    flush = 1'b1;
    flush_pc = 32'h1c00_0100;
    budget = 3;
    push_exp(32'h1c00_0100, 3);
    #1;
    check("flush_req_off", 32'(icu_req), 32'd0);
    step();
    flush = 1'b0;
    #1;
    check("flush_vld_next", 32'(inst_vld_f), 32'd0);
    check("flush_addr_next", icu_addr, 32'h1c00_0100);
    check("flush_credit_req", 32'(icu_req), 32'd0);
    step();
    check("flush_req_resume", 32'(icu_req), 32'd1);
    check("flush_req_addr", icu_addr, 32'h1c00_0100);
    drain("flush2_drain", 60);

    // Flush during stall while a response lands in the flush cycle
    do_reset();
    stall = 1'b1;
    lat = 2;
    budget = 2;
    ack_en = 1'b1;
    step();
    step();
    step();
    check("fs_rvld_in_flush", 32'(icu_rvld), 32'd1);
    check("fs_head_held", inst_addr_f, 32'h1c00_0000);
    flush = 1'b1;
    flush_pc = 32'h1c00_0200;
    budget = 2;
    push_exp(32'h1c00_0200, 2);
    step();
    flush = 1'b0;
    stall = 1'b0;
    #1;
    check("fs_vld_next", 32'(inst_vld_f), 32'd0);
    check("fs_req_next", 32'(icu_req), 32'd1);
    check("fs_addr_next", icu_addr, 32'h1c00_0200);
    drain("fs_drain", 40);

    // Ack back-pressure holds the request address
    do_reset();
    for (int i = 0; i < 5; i++) begin
      check("bp_addr_held", icu_addr, 32'h1c00_0000);
      check("bp_req_held", 32'(icu_req), 32'd1);
      step();
    end
    lat = 1;
    budget = 2;
    ack_en = 1'b1;
    push_exp(32'h1c00_0000, 2);
    drain("bp_drain", 20);

    // PC wrap from the top of the address space
    reset_w = 1'b0;
    #1;
    check("wrap_req", 32'(req_w), 32'd1);
    check("wrap_addr0", addr_w, 32'hffff_fffc);
    step();
    check("wrap_addr1", addr_w, 32'h0000_0000);
    check("wrap_vld", 32'(vld_w), 32'd0);
    check("wrap_fields", iaddr_w | inst_w, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
